finn_rtl_krnl_example_lane_alu: RTL

FINN_RTL_KRNL_EXAMPLE_LANE_ALU -- requirements
Module: finn_rtl_krnl_example_lane_alu

---
 rtl/finn_rtl_krnl_example_lane_alu_pkg.sv | 35 +++
 rtl/finn_rtl_krnl_example_pipe_stage.sv | 27 ++
 rtl/finn_rtl_krnl_example_lane_alu.sv | 122 ++++++++++++
 3 files changed

// File: rtl/finn_rtl_krnl_example_lane_alu_pkg.sv
// Shared types and lane arithmetic for the lane ALU kernel.
// The lane operation is width-generic up to 64 bits; callers truncate the result to their lane width.
package finn_rtl_krnl_example_lane_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD_WRAP = 2'b00,
    OP_ADD_SAT  = 2'b01,
    OP_SUB_SAT  = 2'b10,
    OP_BYPASS   = 2'b11
  } ctrl_op_e;

  localparam int MAX_LANE_W = 64;

  // Operands arrive zero-extended to 64 bits; lw selects the real lane width.
  function automatic logic [MAX_LANE_W-1:0] lane_op(
    input ctrl_op_e              op,
    input logic [MAX_LANE_W-1:0] a,
    input logic [MAX_LANE_W-1:0] b,
    input int                    lw
  );
    logic [MAX_LANE_W:0]   sum;
    logic [MAX_LANE_W-1:0] mask;
    logic [MAX_LANE_W-1:0] r;
    mask = (lw >= MAX_LANE_W) ? {MAX_LANE_W{1'b1}} : ((64'd1 << lw) - 64'd1);
    sum  = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD_WRAP: r = sum[MAX_LANE_W-1:0] & mask;
      OP_ADD_SAT:  r = (sum > {1'b0, mask}) ? mask : sum[MAX_LANE_W-1:0];
      OP_SUB_SAT:  r = (a >= b) ? (a - b) : '0;
      default:     r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/finn_rtl_krnl_example_pipe_stage.sv
// One elastic valid/ready register stage; loads when empty or when its contents leave this cycle.
module finn_rtl_krnl_example_pipe_stage #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/finn_rtl_krnl_example_lane_alu.sv
// Per-lane ALU on an AXI-Stream: one constant applied to every lane, controls fixed per packet,
// followed by a C_PIPE_STAGES deep elastic register pipeline and beat/packet statistics.
module finn_rtl_krnl_example_lane_alu
  import finn_rtl_krnl_example_lane_alu_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_LANE_WIDTH       = 32,
  parameter int C_PIPE_STAGES      = 2
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [C_LANE_WIDTH-1:0]         ctrl_constant,
  input  logic [1:0]                      ctrl_op,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [31:0]                     stat_beat_count,
  output logic [31:0]                     stat_pkt_count
);

  localparam int DW      = C_AXIS_TDATA_WIDTH;
  localparam int LW      = C_LANE_WIDTH;
  localparam int KW      = DW / 8;
  localparam int N_LANES = DW / LW;
  localparam int SW      = DW + KW + 1;
  localparam int NS      = C_PIPE_STAGES;

  if ((DW % LW) != 0 || !(LW == 8 || LW == 16 || LW == 32 || LW == 64) || NS < 1 || NS > 4)
  begin : g_bad_param
    $error("finn_rtl_krnl_example_lane_alu: illegal parameter combination");
  end

  logic        run;
  logic        in_pkt;
  ctrl_op_e    op_q;
  logic [LW-1:0] k_q;
  ctrl_op_e    op_eff;
  logic [LW-1:0] k_eff;
  logic        s_hs;
  logic        m_hs;
  logic [DW-1:0] data_c;

  logic [NS:0]   stg_valid;
  logic [NS:0]   stg_ready;
  logic [SW-1:0] stg_data [NS+1];

  // Holds the input closed for the first edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) run <= 1'b0;
    else          run <= 1'b1;
  end

  assign s_hs = s_axis_tvalid & s_axis_tready;
  assign m_hs = m_axis_tvalid & m_axis_tready;

  // The first beat of a packet uses the live controls; later beats use the copy taken with it.
  assign op_eff = in_pkt ? op_q : ctrl_op_e'(ctrl_op);
  assign k_eff  = in_pkt ? k_q  : ctrl_constant;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_pkt <= 1'b0;
      op_q   <= OP_ADD_WRAP;
      k_q    <= '0;
    end else if (s_hs) begin
      if (!in_pkt) begin
        op_q <= ctrl_op_e'(ctrl_op);
        k_q  <= ctrl_constant;
      end
      in_pkt <= ~s_axis_tlast;
    end
  end

  always_comb begin
    data_c = '0;
    for (int i = 0; i < N_LANES; i++) begin
      data_c[i*LW +: LW] = LW'(lane_op(op_eff, 64'(s_axis_tdata[i*LW +: LW]), 64'(k_eff), LW));
    end
    for (int b = 0; b < KW; b++) begin
      if (!s_axis_tkeep[b]) data_c[b*8 +: 8] = 8'h00;
    end
  end

  assign stg_valid[0] = s_axis_tvalid & run;
  assign stg_data[0]  = {s_axis_tlast, s_axis_tkeep, data_c};
  assign stg_ready[NS] = m_axis_tready;
  assign s_axis_tready = stg_ready[0] & run;

  for (genvar g = 0; g < NS; g++) begin : g_stage
    finn_rtl_krnl_example_pipe_stage #(.W(SW)) u_stage (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .in_valid  (stg_valid[g]),
      .in_ready  (stg_ready[g]),
      .in_data   (stg_data[g]),
      .out_valid (stg_valid[g+1]),
      .out_ready (stg_ready[g+1]),
      .out_data  (stg_data[g+1])
    );
  end

  assign m_axis_tvalid = stg_valid[NS];
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = stg_data[NS];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_beat_count <= '0;
      stat_pkt_count  <= '0;
    end else if (m_hs) begin
      stat_beat_count <= stat_beat_count + 32'd1;
      if (m_axis_tlast) stat_pkt_count <= stat_pkt_count + 32'd1;
    end
  end

endmodule
